// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel engine: two line buffers build the window on the fly
// from a raster pixel stream, one result per accepted interior pixel.
module sobel_stream #(
  parameter int PIXEL_WIDTH = 8,
  parameter int IMG_WIDTH   = 160,
  parameter int IMG_HEIGHT  = 120
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic [1:0]             mode_i,
  input  logic [PIXEL_WIDTH-1:0] threshold_i,
  input  logic                   px_valid_i,
  input  logic [PIXEL_WIDTH-1:0] px_i,
  output logic [PIXEL_WIDTH-1:0] px_o,
  output logic                   px_valid_o,
  output logic                   frame_done_o,
  output logic                   busy_o
);
  localparam int PW = PIXEL_WIDTH;
  localparam int SW = PW + 3;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_e;

  state_e          state_q;
  logic [CW-1:0]   col_q;
  logic [RW-1:0]   row_q;
  logic [1:0]      mode_q;
  logic [PW-1:0]   thr_q;
  logic [PW-1:0]   lb0_q [IMG_WIDTH];
  logic [PW-1:0]   lb1_q [IMG_WIDTH];
  logic [PW-1:0]   win_q [3][3];
  logic            win_vld_q;
  logic [PW-1:0]   px_q;
  logic            vld_q;
  logic            fd_q;
  logic            busy_q;

  logic            start_ok;
  logic            accept;
  logic            col_end;
  logic signed [SW-1:0] gx, gy;
  logic [SW-1:0]   ax, ay, mag;
  logic [PW-1:0]   res_d;

  assign start_ok = start_i && (state_q == IDLE) && !busy_q;
  assign accept   = px_valid_i && ((state_q == FILL) || (state_q == STREAM));
  assign col_end  = (col_q == COL_LAST);

  assign px_o         = px_q;
  assign px_valid_o   = vld_q;
  assign frame_done_o = fd_q;
  assign busy_o       = busy_q;

  function automatic logic signed [SW-1:0] ext(input logic [PW-1:0] p);
    return $signed({3'b000, p});
  endfunction

  function automatic logic [PW-1:0] sat(input logic [SW-1:0] v);
    return (|v[SW-1:PW]) ? {PW{1'b1}} : v[PW-1:0];
  endfunction

  always_comb begin
    gx = (ext(win_q[0][2]) + (ext(win_q[1][2]) <<< 1) + ext(win_q[2][2]))
       - (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1) + ext(win_q[2][0]));
    gy = (ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1) + ext(win_q[2][2]))
       - (ext(win_q[0][0]) + (ext(win_q[0][1]) <<< 1) + ext(win_q[0][2]));
    ax = gx[SW-1] ? $unsigned(-gx) : $unsigned(gx);
    ay = gy[SW-1] ? $unsigned(-gy) : $unsigned(gy);
    mag = ax + ay;
    res_d = '0;
    unique case (mode_q)
      2'd0: res_d = sat(mag);
      2'd1: res_d = (mag >= {3'b000, thr_q}) ? {PW{1'b1}} : '0;
      2'd2: res_d = sat(ax);
      2'd3: res_d = sat(ay);
    endcase
  end

  // Line buffers carry no reset; rows 0-1 rewrite them before use.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= px_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      mode_q    <= '0;
      thr_q     <= '0;
      win_vld_q <= 1'b0;
      px_q      <= '0;
      vld_q     <= 1'b0;
      fd_q      <= 1'b0;
      busy_q    <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      vld_q     <= win_vld_q;
      px_q      <= win_vld_q ? res_d : px_q;
      fd_q      <= (state_q == DONE);
      busy_q    <= (state_q != IDLE) || start_ok;
      win_vld_q <= accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= lb1_q[col_q];
        win_q[1][2] <= lb0_q[col_q];
        win_q[2][2] <= px_i;
        if (col_end) begin
          col_q <= '0;
          row_q <= row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
      unique case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_q <= FILL;
            mode_q  <= mode_i;
            thr_q   <= threshold_i;
            col_q   <= '0;
            row_q   <= '0;
          end
        end
        FILL: begin
          if (accept && col_end && (row_q == RW'(1))) state_q <= STREAM;
        end
        STREAM: begin
          if (accept && col_end && (row_q == ROW_LAST)) state_q <= DONE;
        end
        DONE: state_q <= IDLE;
      endcase
    end
  end

endmodule
